decode_queue: RTL and testbench

Parametrised instruction queue between fetch and decode, with per-entry pre-decode. Fetched instructions are stored in a DEPTH-entry circular buffer under valid/ready handshakes on both sides. Each instruction is checked for an illegal major opcode when it is enqueued, and the result is merged with any exception already carried from fetch. The head entry presents register and CSR addresses so regfile and CSR reads can start from the queue output, and a flush input discards all in-flight instructions on redirect.

---
 rtl/decode_queue.sv | 164 ++++++++++++++++
 tb/tb_decode_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: instruction queue between fetch and decode.
// Entries live in a DEPTH-entry circular buffer. Each instruction is pre-decoded
// for an illegal major opcode at enqueue and merged with any fetch exception. The
// head entry is presented together with the register and CSR addresses it names.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   flush_i                synchronous discard of every queued entry
//   in_valid_i/in_ready_o  fetch-side handshake
//   in_pc_i, in_instr_i    instruction PC and word
//   in_ex_i, in_ex_code_i, in_ex_value_i   exception already raised by fetch
//   out_valid_o/out_ready_i                decode-side handshake
//   out_pc_o, out_instr_o                  head PC and word (zero when empty)
//   out_ex_o, out_ex_code_o, out_ex_value_o merged head exception (zero when empty)
//   out_ra1_o, out_ra2_o, out_csr_addr_o   register/CSR addresses from head word
//   count_o                                number of occupied entries
module decode_queue #(
  parameter int unsigned       XLEN         = 64,
  parameter int unsigned       DEPTH        = 4,
  parameter int unsigned       CODEW        = 4,
  parameter logic [CODEW-1:0]  ILLEGAL_CODE = CODEW'(2),
  parameter logic [31:0]       SKIP_INSTR   = 32'h0005006b
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [XLEN-1:0]              in_pc_i,
  input  logic [31:0]                  in_instr_i,
  input  logic                         in_ex_i,
  input  logic [CODEW-1:0]             in_ex_code_i,
  input  logic [XLEN-1:0]              in_ex_value_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [XLEN-1:0]              out_pc_o,
  output logic [31:0]                  out_instr_o,
  output logic                         out_ex_o,
  output logic [CODEW-1:0]             out_ex_code_o,
  output logic [XLEN-1:0]              out_ex_value_o,
  output logic [4:0]                   out_ra1_o,
  output logic [4:0]                   out_ra2_o,
  output logic [11:0]                  out_csr_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned     PtrW = $clog2(DEPTH);
  localparam int unsigned     CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            enq, deq;

  // Entry storage is deliberately not reset; occupancy alone decides validity.
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic             ex_mem    [DEPTH];
  logic [CODEW-1:0] code_mem  [DEPTH];
  logic [XLEN-1:0]  value_mem [DEPTH];

  // A full queue that drains this cycle still frees a slot for fetch.
  assign in_ready_o  = !flush_i && ((count_q != Full) || out_ready_i);
  assign out_valid_o = (count_q != '0);
  assign enq         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i && !flush_i;
  assign count_o     = count_q;

  // Pre-decode of the incoming word.
  logic             legal;
  logic             ex_new;
  logic [CODEW-1:0] code_new;
  logic [XLEN-1:0]  value_new;

  always_comb begin
    legal = 1'b0;
    if (in_instr_i[1:0] == 2'b11) begin
      case (in_instr_i[6:0])
        7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33,
        7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73: legal = 1'b1;
        default:                                  legal = 1'b0;
      endcase
    end
    if (in_instr_i == SKIP_INSTR) legal = 1'b1;
  end

  // Fetch exception has priority over the illegal-opcode exception.
  always_comb begin
    ex_new    = 1'b0;
    code_new  = '0;
    value_new = '0;
    if (in_ex_i) begin
      ex_new    = 1'b1;
      code_new  = in_ex_code_i;
      value_new = in_ex_value_i;
    end else if (!legal) begin
      ex_new    = 1'b1;
      code_new  = ILLEGAL_CODE;
      value_new = in_pc_i;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth: pointer overflow is the wrap.
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[tail_q]    <= in_pc_i;
      instr_mem[tail_q] <= in_instr_i;
      ex_mem[tail_q]    <= ex_new;
      code_mem[tail_q]  <= code_new;
      value_mem[tail_q] <= value_new;
    end
  end

  always_comb begin
    out_pc_o       = '0;
    out_instr_o    = '0;
    out_ex_o       = 1'b0;
    out_ex_code_o  = '0;
    out_ex_value_o = '0;
    if (out_valid_o) begin
      out_pc_o       = pc_mem[head_q];
      out_instr_o    = instr_mem[head_q];
      out_ex_o       = ex_mem[head_q];
      out_ex_code_o  = code_mem[head_q];
      out_ex_value_o = value_mem[head_q];
    end
  end

  assign out_ra1_o      = out_instr_o[19:15];
  assign out_ra2_o      = out_instr_o[24:20];
  assign out_csr_addr_o = out_instr_o[31:20];

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed stimulus for decode_queue, checked every cycle against
// a queue-based reference model plus literal expectations at key points.
module tb_decode_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CODEW = 4;

  logic             clk, rst_n, flush;
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  in_pc, in_ex_value;
  logic [31:0]      in_instr;
  logic             in_ex;
  logic [CODEW-1:0] in_ex_code;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_pc, out_ex_value;
  logic [31:0]      out_instr;
  logic             out_ex;
  logic [CODEW-1:0] out_ex_code;
  logic [4:0]       out_ra1, out_ra2;
  logic [11:0]      out_csr_addr;
  logic [2:0]       count;

  int n_chk  = 0;
  int n_fail = 0;

  decode_queue #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .CODEW(CODEW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_pc_i       (in_pc),
    .in_instr_i    (in_instr),
    .in_ex_i       (in_ex),
    .in_ex_code_i  (in_ex_code),
    .in_ex_value_i (in_ex_value),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pc_o      (out_pc),
    .out_instr_o   (out_instr),
    .out_ex_o      (out_ex),
    .out_ex_code_o (out_ex_code),
    .out_ex_value_o(out_ex_value),
    .out_ra1_o     (out_ra1),
    .out_ra2_o     (out_ra2),
    .out_csr_addr_o(out_csr_addr),
    .count_o       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        ex;
    logic [3:0]  code;
    logic [63:0] value;
  } ent_t;

  ent_t q[$];

  function automatic bit is_legal(input logic [31:0] i);
    if (i == 32'h0005006b) return 1'b1;
    return (i[1:0] == 2'b11) && (i[6:0] inside {7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23,
                                                7'h33, 7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f,
                                                7'h73});
  endfunction

  function automatic ent_t mk(input logic [63:0] pc, input logic [31:0] instr, input logic ex,
                              input logic [3:0] code, input logic [63:0] value);
    ent_t e;
    e.pc    = pc;
    e.instr = instr;
    if (ex) begin
      e.ex = 1'b1; e.code = code; e.value = value;
    end else if (!is_legal(instr)) begin
      e.ex = 1'b1; e.code = 4'd2; e.value = pc;
    end else begin
      e.ex = 1'b0; e.code = 4'd0; e.value = 64'd0;
    end
    return e;
  endfunction

  bit m_rdy;

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      m_rdy = !flush && (q.size() < DEPTH || out_ready);
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && m_rdy) q.push_back(mk(in_pc, in_instr, in_ex, in_ex_code, in_ex_value));
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  ent_t e_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() != 0) e_exp = q[0];
      else e_exp = '{pc: 64'd0, instr: 32'd0, ex: 1'b0, code: 4'd0, value: 64'd0};
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(!flush && (q.size() < DEPTH || out_ready)));
      chk("out_pc", out_pc, e_exp.pc);
      chk("out_instr", 64'(out_instr), 64'(e_exp.instr));
      chk("out_ex", 64'(out_ex), 64'(e_exp.ex));
      chk("out_ex_code", 64'(out_ex_code), 64'(e_exp.code));
      chk("out_ex_value", out_ex_value, e_exp.value);
      chk("out_ra1", 64'(out_ra1), 64'(e_exp.instr[19:15]));
      chk("out_ra2", 64'(out_ra2), 64'(e_exp.instr[24:20]));
      chk("out_csr_addr", 64'(out_csr_addr), 64'(e_exp.instr[31:20]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [63:0] pc, input logic [31:0] instr, input logic ex,
                      input logic [3:0] code, input logic [63:0] value);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_instr    = instr;
    in_ex       = ex;
    in_ex_code  = code;
    in_ex_value = value;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_ex    = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_ex = 1'b0; in_ex_code = '0; in_ex_value = '0;
    #12 rst_n = 1'b1;

    // Reset state
    mid();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ADDI enqueue then dequeue
    push(64'h8000_0000, 32'h0000_0013, 1'b0, 4'd0, 64'd0);
    mid();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_ex", 64'(out_ex), 64'd0);
    chk("addi_ra1", 64'(out_ra1), 64'd0);
    chk("addi_count", 64'(count), 64'd1);
    chk("addi_pc", out_pc, 64'h8000_0000);
    pop1();
    mid();
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_pc", out_pc, 64'd0);
    chk("drain_instr", 64'(out_instr), 64'd0);

    // Illegal opcode, then the always-legal skip word
    push(64'h1000, 32'hffff_ffff, 1'b0, 4'd0, 64'd0);
    push(64'h1004, 32'h0005_006b, 1'b0, 4'd0, 64'd0);
    mid();
    chk("ill_ex", 64'(out_ex), 64'd1);
    chk("ill_code", 64'(out_ex_code), 64'd2);
    chk("ill_value", out_ex_value, 64'h1000);
    pop1();
    mid();
    chk("skip_ex", 64'(out_ex), 64'd0);
    chk("skip_ra1", 64'(out_ra1), 64'd10);
    pop1();

    // Fetch exception wins over illegal opcode
    push(64'h2000, 32'hffff_ffff, 1'b1, 4'd1, 64'hdead);
    mid();
    chk("fex_code", 64'(out_ex_code), 64'd1);
    chk("fex_value", out_ex_value, 64'hdead);
    pop1();

    // Fill, then full-and-draining with sustained pushes across pointer wrap
    for (int i = 0; i < 4; i++)
      push(64'h3000 + 64'(4 * i), 32'h0000_0013 | (32'(i) << 15), 1'b0, 4'd0, 64'd0);
    mid();
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("full_drain_in_ready", 64'(in_ready), 64'd1);
    for (int i = 4; i < 14; i++) begin
      in_pc    = 64'h3000 + 64'(4 * i);
      in_instr = 32'h0000_0013 | (32'(i) << 15);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    mid();
    chk("wrap_count", 64'(count), 64'd4);
    chk("wrap_head_pc", out_pc, 64'h3028);
    chk("wrap_head_ra1", 64'(out_ra1), 64'd10);
    for (int i = 0; i < 4; i++) pop1();

    // Flush together with an offered instruction
    for (int i = 0; i < 3; i++) push(64'h5000 + 64'(4 * i), 32'h0000_0033, 1'b0, 4'd0, 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h9999; in_instr = 32'h0000_0013;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    mid();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    mid();
    chk("flush_valid_later", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-cycle with two entries queued
    push(64'h6000, 32'h0000_0013, 1'b0, 4'd0, 64'd0);
    push(64'h6004, 32'h0000_0013, 1'b0, 4'd0, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    mid();
    rst_n = 1'b1;
    push(64'h7000, 32'h0000_0073, 1'b0, 4'd0, 64'd0);
    mid();
    chk("post_rst_pc", out_pc, 64'h7000);
    chk("post_rst_count", 64'(count), 64'd1);
    pop1();
    mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
